// File: rtl/frame_swap_scheduler.sv
// Double-buffer frame sequencer: boot blanking, clear, render, swap at frame boundary.
// Optional DROP_STATS_EN adds the saturating repeated-frame counter and its drop_count port.
module frame_swap_scheduler #(
    parameter int BLANK_FRAMES  = 2,
    parameter int CLEAR_TIMEOUT = 4,
    parameter int FRAME_CNT_W   = 16,
    parameter int DROP_CNT_W    = 8
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic                   clear_done,
    input  logic                   render_done,
    output logic                   display_buf,
    output logic                   render_buf,
    output logic                   clear_req,
    output logic                   render_en,
    output logic                   display_blank,
    output logic                   clear_fault,
    output logic [FRAME_CNT_W-1:0] frame_count
`ifdef DROP_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0]  drop_count
`endif
);

    localparam int BW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam int TW = (CLEAR_TIMEOUT > 1) ? $clog2(CLEAR_TIMEOUT) : 1;
    localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_FRAMES);
    localparam logic [TW-1:0] TO_LAST    = TW'(CLEAR_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_CLEAR  = 2'd1,
        S_RENDER = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] blank_cnt, blank_cnt_d;
    logic [TW-1:0] to_cnt, to_cnt_d;
    logic          display_buf_d, clear_req_d, render_en_d;
    logic          display_blank_d, clear_fault_d;

    always_comb begin
        state_d         = state_q;
        blank_cnt_d     = blank_cnt;
        to_cnt_d        = to_cnt;
        display_buf_d   = display_buf;
        clear_req_d     = clear_req;
        render_en_d     = render_en;
        display_blank_d = display_blank;
        clear_fault_d   = clear_fault;
        case (state_q)
            S_BOOT: begin
                if (blank_cnt != '0) begin
                    blank_cnt_d = blank_cnt - 1'b1;
                end else begin
                    state_d     = S_CLEAR;
                    clear_req_d = 1'b1;
                    to_cnt_d    = '0;
                end
            end
            S_CLEAR: begin
                // Render is granted even on timeout so a stuck clear engine cannot freeze the display.
                if (clear_done || to_cnt == TO_LAST) begin
                    state_d     = S_RENDER;
                    clear_req_d = 1'b0;
                    render_en_d = 1'b1;
                    if (!clear_done) clear_fault_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt + 1'b1;
                end
            end
            S_RENDER: begin
                if (render_done) begin
                    state_d         = S_CLEAR;
                    display_buf_d   = ~display_buf;
                    display_blank_d = 1'b0;
                    render_en_d     = 1'b0;
                    clear_req_d     = 1'b1;
                    to_cnt_d        = '0;
                end
            end
            default: begin
                state_d     = S_BOOT;
                clear_req_d = 1'b0;
                render_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q       <= S_BOOT;
            blank_cnt     <= BLANK_INIT;
            to_cnt        <= '0;
            display_buf   <= 1'b0;
            clear_req     <= 1'b0;
            render_en     <= 1'b0;
            display_blank <= 1'b1;
            clear_fault   <= 1'b0;
            frame_count   <= '0;
        end else begin
            state_q       <= state_d;
            blank_cnt     <= blank_cnt_d;
            to_cnt        <= to_cnt_d;
            display_buf   <= display_buf_d;
            clear_req     <= clear_req_d;
            render_en     <= render_en_d;
            display_blank <= display_blank_d;
            clear_fault   <= clear_fault_d;
            frame_count   <= frame_count + 1'b1;
        end
    end

    assign render_buf = ~display_buf;

`ifdef DROP_STATS_EN
    logic drop_inc;
    // A frame is repeated whenever the renderer misses the boundary while it owns the buffer.
    assign drop_inc = (state_q == S_RENDER) && !render_done;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            drop_count <= '0;
        end else if (drop_inc && drop_count != '1) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`else
    logic unused_drop_w;
    assign unused_drop_w = (DROP_CNT_W > 0);
`endif

endmodule

// File: tb/tb_frame_swap_scheduler.sv
// Directed bench for frame_swap_scheduler: event-count model checked every frame plus literal pins.
`timescale 1ns/1ps
module tb_frame_swap_scheduler;

    localparam int BLANK = 2;
    localparam int CT    = 4;
    localparam int FW    = 4;
    localparam int DW    = 8;

    logic          frame_clk = 1'b0;
    logic          Reset = 1'b1;
    logic          clear_done = 1'b0;
    logic          render_done = 1'b0;
    logic          display_buf, render_buf, clear_req, render_en, display_blank, clear_fault;
    logic [FW-1:0] frame_count;
`ifdef DROP_STATS_EN
    logic [DW-1:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    frame_swap_scheduler #(
        .BLANK_FRAMES (BLANK),
        .CLEAR_TIMEOUT(CT),
        .FRAME_CNT_W  (FW),
        .DROP_CNT_W   (DW)
    ) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .clear_done   (clear_done),
        .render_done  (render_done),
        .display_buf  (display_buf),
        .render_buf   (render_buf),
        .clear_req    (clear_req),
        .render_en    (render_en),
        .display_blank(display_blank),
        .clear_fault  (clear_fault),
        .frame_count  (frame_count)
`ifdef DROP_STATS_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model in terms of events: phase, frames seen, swaps done, frames repeated.
    int phase;       // 0 boot, 1 clear, 2 render
    int blank_left, clr_frames, swaps, drops, frames;
    bit fault, mvalid = 1'b0;

    always @(posedge frame_clk) begin
        if (Reset) begin
            phase = 0; blank_left = BLANK; clr_frames = 0;
            swaps = 0; drops = 0; frames = 0; fault = 1'b0; mvalid = 1'b1;
        end else if (mvalid) begin
            frames++;
            case (phase)
                0: if (blank_left > 0) blank_left--; else begin phase = 1; clr_frames = 0; end
                1: if (clear_done) phase = 2;
                   else begin
                       clr_frames++;
                       if (clr_frames == CT) begin phase = 2; fault = 1'b1; end
                   end
                default: if (render_done) begin swaps++; phase = 1; clr_frames = 0; end
                         else drops++;
            endcase
        end
        #1;
        if (mvalid) begin
            chk("m_display_buf", 32'(display_buf), 32'(swaps % 2));
            chk("m_render_buf", 32'(render_buf), 32'(1 - swaps % 2));
            chk("m_display_blank", 32'(display_blank), 32'(swaps == 0));
            chk("m_clear_req", 32'(clear_req), 32'(phase == 1));
            chk("m_render_en", 32'(render_en), 32'(phase == 2));
            chk("m_clear_fault", 32'(clear_fault), 32'(fault));
            chk("m_frame_count", 32'(frame_count), 32'(frames % (1 << FW)));
`ifdef DROP_STATS_EN
            chk("m_drop_count", 32'(drop_count), 32'((drops > 255) ? 255 : drops));
`endif
        end
    end

    task automatic step(input bit r, input bit cd, input bit rd);
        @(negedge frame_clk);
        Reset = r; clear_done = cd; render_done = rd;
        @(posedge frame_clk);
        #2;
    endtask

    initial begin
        step(1, 0, 0);
        chk("rst_display_buf", 32'(display_buf), 32'd0);
        chk("rst_render_buf", 32'(render_buf), 32'd1);
        chk("rst_blank", 32'(display_blank), 32'd1);
        chk("rst_clear_req", 32'(clear_req), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("boot_clear_req", 32'(clear_req), 32'd0);
        chk("boot_render_en", 32'(render_en), 32'd0);
        step(0, 0, 0);
        chk("e3_clear_req", 32'(clear_req), 32'd1);
        chk("e3_frame_count", 32'(frame_count), 32'd3);
        step(0, 1, 0);
        chk("clr_done_render_en", 32'(render_en), 32'd1);
        chk("clr_done_clear_req", 32'(clear_req), 32'd0);
        step(0, 0, 1);
        chk("swap1_display_buf", 32'(display_buf), 32'd1);
        chk("swap1_blank", 32'(display_blank), 32'd0);
        chk("swap1_clear_req", 32'(clear_req), 32'd1);
        chk("swap1_render_en", 32'(render_en), 32'd0);
        step(0, 1, 0);
        repeat (5) step(0, 0, 0);
        chk("late_display_buf", 32'(display_buf), 32'd1);
`ifdef DROP_STATS_EN
        chk("late_drop_count", 32'(drop_count), 32'd5);
`endif
        step(0, 0, 1);
        chk("swap2_display_buf", 32'(display_buf), 32'd0);
        repeat (3) step(0, 0, 0);
        chk("to3_fault", 32'(clear_fault), 32'd0);
        chk("to3_clear_req", 32'(clear_req), 32'd1);
        step(0, 0, 0);
        chk("to4_fault", 32'(clear_fault), 32'd1);
        chk("to4_render_en", 32'(render_en), 32'd1);
        chk("wrap_frame_count", 32'(frame_count), 32'd0);
        step(0, 0, 1);
        chk("swap3_display_buf", 32'(display_buf), 32'd1);
        chk("fault_sticky", 32'(clear_fault), 32'd1);
        step(0, 1, 1);
        chk("both_no_swap", 32'(display_buf), 32'd1);
        chk("both_render_en", 32'(render_en), 32'd1);
        step(0, 1, 1);
        chk("both_next_swap", 32'(display_buf), 32'd0);
        step(0, 1, 0);
        step(1, 0, 0);
        chk("mid_rst_display_buf", 32'(display_buf), 32'd0);
        chk("mid_rst_frame_count", 32'(frame_count), 32'd0);
        chk("mid_rst_blank", 32'(display_blank), 32'd1);
        chk("mid_rst_render_en", 32'(render_en), 32'd0);
        chk("mid_rst_fault", 32'(clear_fault), 32'd0);
        step(0, 0, 0);
        chk("post_rst_boot", 32'(clear_req), 32'd0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        repeat (260) step(0, 0, 0);
        chk("stuck_blank", 32'(display_blank), 32'd1);
`ifdef DROP_STATS_EN
        chk("drop_saturate", 32'(drop_count), 32'd255);
`endif
        for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(0, 49) == 0), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)));
            chk("inv_req_en", 32'(clear_req & render_en), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
